voice_config_bank: RTL and testbench
====================================

# voice_config_bank

Parametrised, double-buffered configuration register bank for the synth voice/operator array. Host register writes land in a shadow copy; the shadow is copied into the active copy driving the cores only at a sample boundary after an explicit commit request, so multi-register updates never produce a half-updated sample. Sits between the host register interface and the core config inputs, replacing ad-hoc per-field decode in the top level.

## Interface
- NUM_VOICES, 8, voice count; legal 1..15
- NUM_OPERATORS, 6, operators per voice; legal 1..6
- i_Clock  in  1  system clock
- i_Reset  in  1  reset i_Reset, synchronous, active-high; clock i_Clock
- i_RegisterNumber  in  16  address: [15:12] voice, [11:9] operator field (0 = voice-level, 1..NUM_OPERATORS), [8:0] register index
- i_RegisterValue  in  16  write data
- i_RegisterWriteEnable  in  1  write strobe, one write per cycle
- i_ReadEnable  in  1  readback strobe
- i_SampleBoundary  in  1  single-cycle pulse from core at sample emission
- o_KeyOn  out  NUM_VOICES  active KeyOn per voice
- o_PhaseStep  out  16*NUM_VOICES*NUM_OPERATORS  active phase steps, voice-major, operator-minor
- o_OutputLevel  out  16*NUM_VOICES*NUM_OPERATORS  active operator levels, same packing
- o_CommitPending  out  1  commit requested, not yet applied
- o_CommitDone  out  1  one-cycle pulse after active copy updated
- o_WriteError  out  1  one-cycle pulse after a write to an unmapped address
- o_ReadData  out  16  readback data
- o_ReadValid  out  1  readback qualifier

## Operation
- Register map (shadow): voice-level idx 0 = KeyOn (bit 0; others ignored, read 0); operator-level idx 0 = PhaseStep, idx 1 = OutputLevel; CONTROL at 0xFE00.
- Examples: voice 2 KeyOn 0x2000; voice 2 op 3 PhaseStep 0x2600; voice 0 op 1 OutputLevel 0x0201.
- CONTROL write: bit 0 = 1 sets pending; bit 0 = 0 no effect. CONTROL read = {15'b0, pending}.
- Unmapped: voice >= NUM_VOICES (except CONTROL), operator field > NUM_OPERATORS, other indices. Write ignored, o_WriteError pulses.
- Commit: i_SampleBoundary while pending -> active <= entire shadow, pending cleared, o_CommitDone pulses next cycle. Boundary without pending: nothing.
- Data writes never set pending.

## Timing
- Reset: all shadow and active fields 0, pending 0; every output 0.
- Write at edge N visible in shadow/readback from cycle N+1; in active only after a later commit.
- Commit: boundary sampled at edge N -> o_KeyOn/o_PhaseStep/o_OutputLevel new from N+1, o_CommitDone high cycle N+1, o_CommitPending low from N+1.
- Write and boundary same cycle: commit copies pre-write shadow; the write stays in shadow.
- CONTROL set and boundary same cycle: pending set, commit waits for next boundary.
- Read: i_ReadEnable at edge N -> o_ReadData/o_ReadValid in cycle N+1, one-cycle valid; same-cycle write to same address returns old value. Unmapped reads return 0 with o_ReadValid high.
- Reset mid-operation overrides pending commit, write and read in that cycle.

## Configuration
- VOICE_CONFIG_READBACK_EN defined: readback path as above.
- Undefined: read mux absent; o_ReadData and o_ReadValid tied 0; i_ReadEnable ignored; writes and commits unchanged.

## Structure
- synth_pkg: field widths (4/3/9), register index constants (KEYON, PHASESTEP, OUTPUTLEVEL), CONTROL address 16'hFE00, per-operator config struct.
- Sub-module voice_config_decode: combinational address decode to voice, operator, index, is_control, valid; shared by write and read paths.

## Test plan
- Reset, write 0x1234 to 0x2600, CONTROL=1, boundary -> o_PhaseStep voice 2 op 3 = 0x1234 cycle after boundary, o_CommitDone one pulse, pending 0.
- Write KeyOn voice 0 =1, boundary with no CONTROL write -> o_KeyOn stays 0; CONTROL=1 then boundary -> o_KeyOn[0]=1.
- Write 0x00AA to 0x0201 in same cycle as boundary with pending -> active OutputLevel unchanged; after next CONTROL+boundary = 0x00AA.
- Write to 0x8000 (NUM_VOICES=8) and 0x0E00 -> o_WriteError pulses each, no state change.
- (Readback enabled) write 0x5555 to 0x0200, read next cycle -> o_ReadData=0x5555, o_ReadValid one cycle; read 0xFE00 with pending -> 0x0001.
- Assert i_Reset with pending and committed state -> all outputs 0, later boundary produces no o_CommitDone.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared field widths, register indices and per-operator config layout for
// the voice configuration bank.
package synth_pkg;

  localparam int VOICE_W = 4;
  localparam int OPER_W  = 3;
  localparam int INDEX_W = 9;

  localparam logic [INDEX_W-1:0] IDX_KEYON       = 9'd0;
  localparam logic [INDEX_W-1:0] IDX_PHASESTEP   = 9'd0;
  localparam logic [INDEX_W-1:0] IDX_OUTPUTLEVEL = 9'd1;

  localparam logic [15:0] CONTROL_ADDR = 16'hFE00;

  typedef struct packed {
    logic [15:0] phase_step;
    logic [15:0] output_level;
  } operator_cfg_t;

endpackage

// File: rtl/voice_config_decode.sv
// Combinational host-address decode into voice / operator field / index,
// flagging the CONTROL register and mapped data registers.
module voice_config_decode
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 8,
  parameter int NUM_OPERATORS = 6
) (
  input  logic [15:0]        addr_i,
  output logic [VOICE_W-1:0] voice_o,
  output logic [OPER_W-1:0]  oper_o,
  output logic [INDEX_W-1:0] index_o,
  output logic               is_control_o,
  output logic               valid_o
);

  localparam logic [VOICE_W-1:0] NV = VOICE_W'(NUM_VOICES);
  localparam logic [OPER_W-1:0]  NO = OPER_W'(NUM_OPERATORS);

  logic voice_ok;
  logic voice_reg;
  logic oper_reg;

  assign voice_o      = addr_i[15:12];
  assign oper_o       = addr_i[11:9];
  assign index_o      = addr_i[8:0];
  assign is_control_o = (addr_i == CONTROL_ADDR);

  // CONTROL lives at voice 15, which is never a mapped voice, so the two flags are exclusive.
  assign voice_ok  = (voice_o < NV);
  assign voice_reg = (oper_o == '0) && (index_o == IDX_KEYON);
  assign oper_reg  = (oper_o != '0) && (oper_o <= NO) &&
                     ((index_o == IDX_PHASESTEP) || (index_o == IDX_OUTPUTLEVEL));
  assign valid_o   = voice_ok && (voice_reg || oper_reg);

endmodule

// File: rtl/voice_config_bank.sv
// Double-buffered voice/operator config bank: host writes hit the shadow copy,
// which moves to the active copy at a sample boundary after a commit request.
// Optional readback path enabled by defining VOICE_CONFIG_READBACK_EN.
module voice_config_bank
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 8,
  parameter int NUM_OPERATORS = 6
) (
  input  logic                                    i_Clock,
  input  logic                                    i_Reset,
  input  logic [15:0]                             i_RegisterNumber,
  input  logic [15:0]                             i_RegisterValue,
  input  logic                                    i_RegisterWriteEnable,
  input  logic                                    i_ReadEnable,
  input  logic                                    i_SampleBoundary,
  output logic [NUM_VOICES-1:0]                   o_KeyOn,
  output logic [16*NUM_VOICES*NUM_OPERATORS-1:0]  o_PhaseStep,
  output logic [16*NUM_VOICES*NUM_OPERATORS-1:0]  o_OutputLevel,
  output logic                                    o_CommitPending,
  output logic                                    o_CommitDone,
  output logic                                    o_WriteError,
  output logic [15:0]                             o_ReadData,
  output logic                                    o_ReadValid
);

  logic [VOICE_W-1:0] dec_voice;
  logic [OPER_W-1:0]  dec_oper;
  logic [INDEX_W-1:0] dec_index;
  logic               dec_is_control;
  logic               dec_valid;

  voice_config_decode #(
    .NUM_VOICES    (NUM_VOICES),
    .NUM_OPERATORS (NUM_OPERATORS)
  ) u_decode (
    .addr_i       (i_RegisterNumber),
    .voice_o      (dec_voice),
    .oper_o       (dec_oper),
    .index_o      (dec_index),
    .is_control_o (dec_is_control),
    .valid_o      (dec_valid)
  );

  logic [NUM_VOICES-1:0] shadow_keyon_q, shadow_keyon_d;
  logic [NUM_VOICES-1:0] active_keyon_q, active_keyon_d;
  operator_cfg_t         shadow_op_q [NUM_VOICES][NUM_OPERATORS];
  operator_cfg_t         shadow_op_d [NUM_VOICES][NUM_OPERATORS];
  operator_cfg_t         active_op_q [NUM_VOICES][NUM_OPERATORS];
  operator_cfg_t         active_op_d [NUM_VOICES][NUM_OPERATORS];
  logic                  pending_q, pending_d;
  logic                  commit_done_q, commit_done_d;
  logic                  write_error_q, write_error_d;

  always_comb begin
    shadow_keyon_d = shadow_keyon_q;
    active_keyon_d = active_keyon_q;
    shadow_op_d    = shadow_op_q;
    active_op_d    = active_op_q;
    pending_d      = pending_q;
    commit_done_d  = 1'b0;
    write_error_d  = 1'b0;

    // Commit copies the pre-write shadow; a same-cycle write lands only in the shadow.
    if (i_SampleBoundary && pending_q) begin
      active_keyon_d = shadow_keyon_q;
      active_op_d    = shadow_op_q;
      pending_d      = 1'b0;
      commit_done_d  = 1'b1;
    end

    if (i_RegisterWriteEnable) begin
      if (dec_is_control) begin
        if (i_RegisterValue[0]) pending_d = 1'b1;
      end else if (!dec_valid) begin
        write_error_d = 1'b1;
      end else begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (dec_voice == VOICE_W'(v)) begin
            if (dec_oper == '0) shadow_keyon_d[v] = i_RegisterValue[0];
            for (int o = 0; o < NUM_OPERATORS; o++) begin
              if (dec_oper == OPER_W'(o + 1)) begin
                if (dec_index == IDX_OUTPUTLEVEL)
                  shadow_op_d[v][o].output_level = i_RegisterValue;
                else
                  shadow_op_d[v][o].phase_step = i_RegisterValue;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      shadow_keyon_q <= '0;
      active_keyon_q <= '0;
      shadow_op_q    <= '{default: '0};
      active_op_q    <= '{default: '0};
      pending_q      <= 1'b0;
      commit_done_q  <= 1'b0;
      write_error_q  <= 1'b0;
    end else begin
      shadow_keyon_q <= shadow_keyon_d;
      active_keyon_q <= active_keyon_d;
      shadow_op_q    <= shadow_op_d;
      active_op_q    <= active_op_d;
      pending_q      <= pending_d;
      commit_done_q  <= commit_done_d;
      write_error_q  <= write_error_d;
    end
  end

  assign o_KeyOn         = active_keyon_q;
  assign o_CommitPending = pending_q;
  assign o_CommitDone    = commit_done_q;
  assign o_WriteError    = write_error_q;

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
    for (genvar go = 0; go < NUM_OPERATORS; go++) begin : g_oper
      assign o_PhaseStep[16*(gv*NUM_OPERATORS+go) +: 16]   = active_op_q[gv][go].phase_step;
      assign o_OutputLevel[16*(gv*NUM_OPERATORS+go) +: 16] = active_op_q[gv][go].output_level;
    end
  end

`ifdef VOICE_CONFIG_READBACK_EN
  logic [15:0] read_data_q, read_data_d;
  logic        read_valid_q;

  always_comb begin
    read_data_d = '0;
    if (dec_is_control) begin
      read_data_d = {15'b0, pending_q};
    end else if (dec_valid) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (dec_voice == VOICE_W'(v)) begin
          if (dec_oper == '0) read_data_d = {15'b0, shadow_keyon_q[v]};
          for (int o = 0; o < NUM_OPERATORS; o++) begin
            if (dec_oper == OPER_W'(o + 1)) begin
              if (dec_index == IDX_OUTPUTLEVEL)
                read_data_d = shadow_op_q[v][o].output_level;
              else
                read_data_d = shadow_op_q[v][o].phase_step;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= i_ReadEnable;
      read_data_q  <= i_ReadEnable ? read_data_d : 16'h0000;
    end
  end

  assign o_ReadData  = read_data_q;
  assign o_ReadValid = read_valid_q;
`else
  logic unused_read_en;
  assign unused_read_en = i_ReadEnable;
  assign o_ReadData     = '0;
  assign o_ReadValid    = 1'b0;
`endif

endmodule

// File: tb/tb_voice_config_bank.sv
// Self-checking bench for voice_config_bank: directed scenarios plus a
// randomized run compared against a register-map level reference model.
module tb_voice_config_bank;

  localparam int NV = 8;
  localparam int NO = 6;
  localparam int W  = 16 * NV * NO;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   reg_num = '0;
  logic [15:0]   reg_val = '0;
  logic          reg_we = 1'b0;
  logic          rd_en = 1'b0;
  logic          sb = 1'b0;
  logic [NV-1:0] key_on;
  logic [W-1:0]  phase_step;
  logic [W-1:0]  out_level;
  logic          commit_pending;
  logic          commit_done;
  logic          write_error;
  logic [15:0]   read_data;
  logic          read_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  voice_config_bank #(.NUM_VOICES(NV), .NUM_OPERATORS(NO)) dut (
    .i_Clock               (clk),
    .i_Reset               (rst),
    .i_RegisterNumber      (reg_num),
    .i_RegisterValue       (reg_val),
    .i_RegisterWriteEnable (reg_we),
    .i_ReadEnable          (rd_en),
    .i_SampleBoundary      (sb),
    .o_KeyOn               (key_on),
    .o_PhaseStep           (phase_step),
    .o_OutputLevel         (out_level),
    .o_CommitPending       (commit_pending),
    .o_CommitDone          (commit_done),
    .o_WriteError          (write_error),
    .o_ReadData            (read_data),
    .o_ReadValid           (read_valid)
  );

  // Reference model: register map as plain arrays, operator slots 1..NO.
  logic [15:0] m_sh_ps [NV][NO+1];
  logic [15:0] m_sh_ol [NV][NO+1];
  logic [15:0] m_ac_ps [NV][NO+1];
  logic [15:0] m_ac_ol [NV][NO+1];
  bit          m_sh_key [NV];
  bit          m_ac_key [NV];
  bit          m_pend, m_done, m_werr, m_rv;
  logic [15:0] m_rd;

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_sh_key[v] = 0; m_ac_key[v] = 0;
      for (int o = 0; o <= NO; o++) begin
        m_sh_ps[v][o] = 0; m_sh_ol[v][o] = 0; m_ac_ps[v][o] = 0; m_ac_ol[v][o] = 0;
      end
    end
    m_pend = 0; m_done = 0; m_werr = 0; m_rv = 0; m_rd = 0;
  endtask

  task automatic model_step(input bit we, input logic [15:0] addr, input logic [15:0] val,
                            input bit re, input bit bnd, input bit r);
    int v, f, idx;
    bit ctl, mapped, old_pend;
    v   = int'(addr) / 4096;
    f   = (int'(addr) / 512) % 8;
    idx = int'(addr) % 512;
    ctl = (addr == 16'hFE00);
    mapped = (v < NV) && ((f == 0 && idx == 0) || (f >= 1 && f <= NO && idx <= 1));
    if (r) begin
      model_clear();
      return;
    end
    old_pend = m_pend;
    m_rv = 0; m_rd = 0;
`ifdef VOICE_CONFIG_READBACK_EN
    if (re) begin
      m_rv = 1;
      if (ctl) m_rd = {15'b0, old_pend};
      else if (mapped) m_rd = (f == 0) ? {15'b0, m_sh_key[v]} : (idx == 0 ? m_sh_ps[v][f] : m_sh_ol[v][f]);
    end
`endif
    m_done = bnd && old_pend;
    if (m_done) begin
      m_pend = 0;
      m_ac_key = m_sh_key; m_ac_ps = m_sh_ps; m_ac_ol = m_sh_ol;
    end
    m_werr = 0;
    if (we) begin
      if (ctl) begin
        if (val[0]) m_pend = 1;
      end else if (!mapped) m_werr = 1;
      else if (f == 0) m_sh_key[v] = val[0];
      else if (idx == 0) m_sh_ps[v][f] = val;
      else m_sh_ol[v][f] = val;
    end
  endtask

  function automatic logic [W-1:0] model_ps();
    logic [W-1:0] r = '0;
    for (int v = 0; v < NV; v++)
      for (int o = 1; o <= NO; o++) r[16*(v*NO+o-1) +: 16] = m_ac_ps[v][o];
    return r;
  endfunction

  function automatic logic [W-1:0] model_ol();
    logic [W-1:0] r = '0;
    for (int v = 0; v < NV; v++)
      for (int o = 1; o <= NO; o++) r[16*(v*NO+o-1) +: 16] = m_ac_ol[v][o];
    return r;
  endfunction

  function automatic logic [NV-1:0] model_key();
    logic [NV-1:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_ac_key[v];
    return r;
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit after it.
  task automatic tick(input bit we, input logic [15:0] addr, input logic [15:0] val,
                      input bit re, input bit bnd, input bit r);
    reg_we = we; reg_num = addr; reg_val = val; rd_en = re; sb = bnd; rst = r;
    @(posedge clk);
    model_step(we, addr, val, re, bnd, r);
    #1;
    reg_we = 0; rd_en = 0; sb = 0; rst = 0;
  endtask

  task automatic idle();
    tick(0, 16'h0000, 16'h0000, 0, 0, 0);
  endtask

  task automatic test_reset();
    tick(0, 16'h0000, 16'h0000, 0, 0, 1);
    tick(0, 16'h0000, 16'h0000, 0, 0, 1);
    n_checks++; if (key_on !== '0) begin n_fail++; $display("FAIL reset_keyon got %h want 0", key_on); end
    n_checks++; if (phase_step !== '0) begin n_fail++; $display("FAIL reset_phase got nonzero want 0"); end
    n_checks++; if (out_level !== '0) begin n_fail++; $display("FAIL reset_level got nonzero want 0"); end
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", commit_pending); end
    n_checks++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", commit_done); end
    n_checks++; if (write_error !== 1'b0) begin n_fail++; $display("FAIL reset_werr got %b want 0", write_error); end
    n_checks++; if (read_valid !== 1'b0 || read_data !== 16'h0) begin n_fail++; $display("FAIL reset_read got %b/%h want 0/0000", read_valid, read_data); end
  endtask

  task automatic test_basic_commit();
    tick(1, 16'h2600, 16'h1234, 0, 0, 0);
    n_checks++; if (phase_step[14*16 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL shadow_leak got %h want 0000", phase_step[14*16 +: 16]); end
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL pending_set got %b want 1", commit_pending); end
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (phase_step[14*16 +: 16] !== 16'h1234) begin n_fail++; $display("FAIL commit_phase got %h want 1234", phase_step[14*16 +: 16]); end
    n_checks++; if (commit_done !== 1'b1) begin n_fail++; $display("FAIL commit_done got %b want 1", commit_done); end
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_clear got %b want 0", commit_pending); end
    idle();
    n_checks++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", commit_done); end
  endtask

  task automatic test_keyon_needs_commit();
    tick(1, 16'h0000, 16'h0001, 0, 0, 0);
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (key_on !== 8'h00) begin n_fail++; $display("FAIL keyon_nocommit got %h want 00", key_on); end
    n_checks++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL done_nopend got %b want 0", commit_done); end
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (key_on !== 8'h01) begin n_fail++; $display("FAIL keyon_commit got %h want 01", key_on); end
  endtask

  task automatic test_write_during_boundary();
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
    tick(1, 16'h0201, 16'h00AA, 0, 1, 0);
    n_checks++; if (out_level[15:0] !== 16'h0000) begin n_fail++; $display("FAIL wr_bnd_level got %h want 0000", out_level[15:0]); end
    n_checks++; if (commit_done !== 1'b1) begin n_fail++; $display("FAIL wr_bnd_done got %b want 1", commit_done); end
    tick(1, 16'hFE00, 16'h0001, 0, 1, 0);
    n_checks++; if (commit_pending !== 1'b1 || commit_done !== 1'b0) begin n_fail++; $display("FAIL ctl_bnd got pend %b done %b want 1 0", commit_pending, commit_done); end
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (out_level[15:0] !== 16'h00AA) begin n_fail++; $display("FAIL wr_bnd_later got %h want 00AA", out_level[15:0]); end
  endtask

  task automatic test_unmapped();
    tick(1, 16'h8000, 16'hFFFF, 0, 0, 0);
    n_checks++; if (write_error !== 1'b1) begin n_fail++; $display("FAIL werr_voice got %b want 1", write_error); end
    tick(1, 16'h0E00, 16'hFFFF, 0, 0, 0);
    n_checks++; if (write_error !== 1'b1) begin n_fail++; $display("FAIL werr_oper got %b want 1", write_error); end
    tick(1, 16'hFE00, 16'h0000, 0, 0, 0);
    n_checks++; if (write_error !== 1'b0 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL ctl_zero got werr %b pend %b want 0 0", write_error, commit_pending); end
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (key_on !== 8'h01 || phase_step !== model_ps() || out_level !== model_ol()) begin n_fail++; $display("FAIL unmapped_state got key %h want 01", key_on); end
    n_checks++; if (phase_step[14*16 +: 16] !== 16'h1234 || out_level[15:0] !== 16'h00AA) begin n_fail++; $display("FAIL unmapped_fields got %h/%h want 1234/00AA", phase_step[14*16 +: 16], out_level[15:0]); end
  endtask

  task automatic test_readback();
`ifdef VOICE_CONFIG_READBACK_EN
    tick(1, 16'h0200, 16'h5555, 0, 0, 0);
    tick(1, 16'h0200, 16'h7777, 1, 0, 0);
    n_checks++; if (read_valid !== 1'b1 || read_data !== 16'h5555) begin n_fail++; $display("FAIL read_old got %b/%h want 1/5555", read_valid, read_data); end
    idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL read_pulse got %b want 0", read_valid); end
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
    tick(0, 16'hFE00, 16'h0000, 1, 0, 0);
    n_checks++; if (read_data !== 16'h0001) begin n_fail++; $display("FAIL read_ctl got %h want 0001", read_data); end
    tick(0, 16'h8000, 16'h0000, 1, 0, 0);
    n_checks++; if (read_valid !== 1'b1 || read_data !== 16'h0000) begin n_fail++; $display("FAIL read_unmapped got %b/%h want 1/0000", read_valid, read_data); end
`else
    tick(0, 16'h0200, 16'h0000, 1, 0, 0);
    n_checks++; if (read_valid !== 1'b0 || read_data !== 16'h0000) begin n_fail++; $display("FAIL read_disabled got %b/%h want 0/0000", read_valid, read_data); end
    tick(1, 16'hFE00, 16'h0001, 0, 0, 0);
`endif
  endtask

  task automatic test_reset_mid();
    tick(1, 16'h0000, 16'h0001, 1, 1, 1);
    n_checks++; if (key_on !== '0 || phase_step !== '0 || out_level !== '0) begin n_fail++; $display("FAIL midrst_active got key %h want 00", key_on); end
    n_checks++; if (commit_pending !== 1'b0 || commit_done !== 1'b0 || read_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got %b%b%b want 000", commit_pending, commit_done, read_valid); end
    tick(0, 16'h0000, 16'h0000, 0, 1, 0);
    n_checks++; if (commit_done !== 1'b0 || key_on !== '0) begin n_fail++; $display("FAIL midrst_bnd got done %b key %h want 0 00", commit_done, key_on); end
  endtask

  task automatic test_random();
    logic [15:0] addr, val;
    bit we, re, bnd, r;
    int shown = 0;
    tick(0, 16'h0000, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = 16'hFE00;
        1:       addr = 16'($urandom);
        2:       addr = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 9'($urandom_range(0, 3))};
        3:       addr = {4'($urandom_range(0, NV-1)), 3'd0, 9'd0};
        default: addr = {4'($urandom_range(0, NV-1)), 3'($urandom_range(1, NO)), 9'($urandom_range(0, 1))};
      endcase
      val = 16'($urandom);
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 2) == 0);
      bnd = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 99) == 0);
      tick(we, addr, val, re, bnd, r);
      n_checks++;
      if (key_on !== model_key() || phase_step !== model_ps() || out_level !== model_ol()) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_active cyc %0d got key %h want %h", i, key_on, model_key());
      end
      n_checks++;
      if (commit_pending !== m_pend || commit_done !== m_done || write_error !== m_werr) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_flags cyc %0d got %b%b%b want %b%b%b", i, commit_pending, commit_done, write_error, m_pend, m_done, m_werr);
      end
      n_checks++;
      if (read_valid !== m_rv || read_data !== m_rd) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_read cyc %0d got %b/%h want %b/%h", i, read_valid, read_data, m_rv, m_rd);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_commit();
    test_keyon_needs_commit();
    test_write_during_boundary();
    test_unmapped();
    test_readback();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
